imm_ext_arbiter: RTL and testbench
==================================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset_L, input, 1 bit: synchronous active-low reset, sampled on the CLK rising edge.
REQ-003 SHALL have ports Req0Valid, Req1Valid, input, 1 bit each: requester 0 (decode) and requester 1 (branch-target) present a request.
REQ-004 SHALL have ports Req0Imm26, Req1Imm26, input, 26 bits each: instruction bits 25-0 for each requester.
REQ-005 SHALL have ports Req0Ctrl, Req1Ctrl, input, 3 bits each: extender control code for each requester.
REQ-006 SHALL have ports Req0Ready, Req1Ready, output, 1 bit each: request accepted this cycle when Valid and Ready are both 1.
REQ-007 SHALL have ports ExtImm26 (26 bits) and ExtCtrl (3 bits), outputs: drive the shared sign-extension unit.
REQ-008 SHALL have port ExtBusImm, input, 64 bits: combinational result from the shared sign-extension unit.
REQ-009 SHALL have ports RspValid (1 bit), RspBusImm (64 bits), RspId (1 bit), RspErr (1 bit), outputs: registered response, owning requester, illegal-code flag.
REQ-010 SHALL have port RspReady, input, 1 bit: response consumed when RspValid and RspReady are both 1.

Function
REQ-011 SHALL implement two states: EMPTY (no response held) and FULL (response held, RspValid=1).
REQ-012 SHALL accept a request when in EMPTY, or in FULL with RspReady=1 in the same cycle (pass-through, no bubble).
REQ-013 SHALL grant at most one request per cycle; the losing requester's Ready SHALL be 0.
REQ-014 SHALL arbitrate round-robin: when both requesters are valid, grant the requester that did not win the last grant; the pointer updates only on an accepted grant.
REQ-015 SHALL drive ExtImm26/ExtCtrl combinationally from the granted requester, and from requester 0 when there is no grant.
REQ-016 SHALL register ExtBusImm into RspBusImm at the accepting edge; RspValid SHALL be 1 in the following cycle (one-cycle latency).
REQ-017 SHALL treat Ctrl 101, 110 and 111 as illegal: respond with RspErr=1 and RspBusImm=0.
REQ-018 SHALL hold RspBusImm, RspId and RspErr stable while in FULL with RspReady=0.
REQ-019 SHALL move FULL to EMPTY when RspReady=1 and no request is accepted that cycle.
REQ-020 SHALL hold Req0Ready=Req1Ready=0 while in FULL with RspReady=0.

Reset
REQ-021 SHALL, with Reset_L=0 at a CLK edge, enter EMPTY, clear RspValid, RspBusImm, RspId and RspErr to 0, and set the round-robin pointer so that requester 0 wins first.
REQ-022 SHALL force Req0Ready=Req1Ready=0 while Reset_L=0; a response in flight at reset SHALL be discarded.

Configuration
REQ-023 SHALL support the macro IMM_EXT_ARB_BSHIFT_EN: when defined, results for Ctrl 010 and 011 are shifted left by 2 (low bits zero) before being registered. When undefined, ExtBusImm is registered unmodified.

Verification
REQ-024 SHALL verify single request: Req0 Ctrl=000, Imm26[21:10]=12'hABC -> next cycle RspValid=1, RspBusImm=64'h0ABC, RspId=0, RspErr=0.
REQ-025 SHALL verify fairness: both requesters valid continuously after reset with RspReady=1 -> grants alternate 0,1,0,1 with one response per cycle.
REQ-026 SHALL verify backpressure: RspReady=0 for 3 cycles while FULL -> response held unchanged, both Ready=0; then RspReady=1 -> pass-through accept in the same cycle.
REQ-027 SHALL verify the illegal code: Req1 Ctrl=110 -> RspErr=1, RspBusImm=0, RspId=1.
REQ-028 SHALL verify the macro: Ctrl=010, Imm26=26'h3FFFFFF -> RspBusImm=64'hFFFFFFFFFFFFFFFF without IMM_EXT_ARB_BSHIFT_EN, 64'hFFFFFFFFFFFFFFFC with it.
REQ-029 SHALL verify reset mid-operation: Reset_L=0 while FULL -> next cycle RspValid=0, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one sign-extension unit between two requesters.
// Define IMM_EXT_ARB_BSHIFT_EN to shift branch-type results (Ctrl 010/011) left by 2.
module imm_ext_arbiter (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        Req0Valid,
   input  logic [25:0] Req0Imm26,
   input  logic [2:0]  Req0Ctrl,
   output logic        Req0Ready,
   input  logic        Req1Valid,
   input  logic [25:0] Req1Imm26,
   input  logic [2:0]  Req1Ctrl,
   output logic        Req1Ready,
   output logic [25:0] ExtImm26,
   output logic [2:0]  ExtCtrl,
   input  logic [63:0] ExtBusImm,
   output logic        RspValid,
   output logic [63:0] RspBusImm,
   output logic        RspId,
   output logic        RspErr,
   input  logic        RspReady
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [63:0] bus_q, bus_d;
   logic        id_q, id_d, err_q, err_d;
   logic        open, gnt0, gnt1, acc, illegal;
   logic [63:0] res;
   always_comb begin
      open      = Reset_L && (state_q == EMPTY || RspReady);
      // last_q holds the previous winner, so a tie goes to the other requester
      gnt0      = Req0Valid && (!Req1Valid || last_q);
      gnt1      = Req1Valid && (!Req0Valid || !last_q);
      Req0Ready = open && gnt0;
      Req1Ready = open && gnt1;
      acc       = Req0Ready || Req1Ready;
      ExtImm26  = Req1Ready ? Req1Imm26 : Req0Imm26;
      ExtCtrl   = Req1Ready ? Req1Ctrl : Req0Ctrl;
      illegal   = ExtCtrl[2] && (ExtCtrl[1] || ExtCtrl[0]);
`ifdef IMM_EXT_ARB_BSHIFT_EN
      res       = illegal ? '0 : (ExtCtrl[2:1] == 2'b01) ? {ExtBusImm[61:0], 2'b00} : ExtBusImm;
`else
      res       = illegal ? '0 : ExtBusImm;
`endif
      state_d   = acc ? FULL : (RspReady ? EMPTY : state_q);
      last_d    = acc ? Req1Ready : last_q;
      bus_d     = acc ? res : bus_q;
      id_d      = acc ? Req1Ready : id_q;
      err_d     = acc ? illegal : err_q;
   end
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state_q <= EMPTY;
         last_q  <= 1'b1;
         bus_q   <= '0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         bus_q   <= bus_d;
         id_q    <= id_d;
         err_q   <= err_d;
      end
   end
   assign RspValid  = (state_q == FULL);
   assign RspBusImm = bus_q;
   assign RspId     = id_q;
   assign RspErr    = err_q;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed stimulus, per-cycle model comparison and literal spot checks.
module tb_imm_ext_arbiter;
   logic        CLK = 0, Reset_L = 0, RspReady = 0;
   logic        Req0Valid = 0, Req1Valid = 0;
   logic [25:0] Req0Imm26 = 0, Req1Imm26 = 0;
   logic [2:0]  Req0Ctrl = 0, Req1Ctrl = 0;
   logic        Req0Ready, Req1Ready, RspValid, RspId, RspErr;
   logic [25:0] ExtImm26;
   logic [2:0]  ExtCtrl;
   logic [63:0] ExtBusImm, RspBusImm;
   int total = 0, bad = 0;
   bit          m_valid = 0, m_prev = 1, m_id = 0, m_err = 0;
   logic [63:0] m_bus = 0;

   imm_ext_arbiter dut (
      .CLK(CLK), .Reset_L(Reset_L),
      .Req0Valid(Req0Valid), .Req0Imm26(Req0Imm26), .Req0Ctrl(Req0Ctrl), .Req0Ready(Req0Ready),
      .Req1Valid(Req1Valid), .Req1Imm26(Req1Imm26), .Req1Ctrl(Req1Ctrl), .Req1Ready(Req1Ready),
      .ExtImm26(ExtImm26), .ExtCtrl(ExtCtrl), .ExtBusImm(ExtBusImm),
      .RspValid(RspValid), .RspBusImm(RspBusImm), .RspId(RspId), .RspErr(RspErr),
      .RspReady(RspReady)
   );

   always #5 CLK = ~CLK;

   // external sign-extension unit; illegal codes yield garbage the DUT must suppress
   function automatic logic [63:0] ext(input logic [25:0] i, input logic [2:0] c);
      case (c)
         3'b000:  return {52'b0, i[21:10]};
         3'b001:  return {{55{i[20]}}, i[20:12]};
         3'b010:  return {{38{i[25]}}, i};
         3'b011:  return {{45{i[23]}}, i[23:5]};
         3'b100:  return {48'b0, i[20:5]};
         default: return 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
   endfunction
   assign ExtBusImm = ext(ExtImm26, ExtCtrl);

   function automatic bit is_bad(input logic [2:0] c);
      return c == 3'd5 || c == 3'd6 || c == 3'd7;
   endfunction

   function automatic logic [63:0] expect_res(input logic [25:0] i, input logic [2:0] c);
      if (is_bad(c)) return 64'd0;
`ifdef IMM_EXT_ARB_BSHIFT_EN
      if (c == 3'd2 || c == 3'd3) return ext(i, c) * 64'd4;
`endif
      return ext(i, c);
   endfunction

   // which requester is accepted now: -1 none, else its id
   function automatic int winner();
      if (!Reset_L || (m_valid && !RspReady)) return -1;
      if (Req0Valid && Req1Valid) return (m_prev == 0) ? 1 : 0;
      if (Req0Valid) return 0;
      if (Req1Valid) return 1;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(posedge CLK) begin
      int w;
      w = winner();
      if (!Reset_L) begin
         m_valid = 0; m_prev = 1; m_bus = 0; m_id = 0; m_err = 0;
      end else if (w >= 0) begin
         m_valid = 1;
         m_id    = w[0];
         m_prev  = w[0];
         m_bus   = w == 1 ? expect_res(Req1Imm26, Req1Ctrl) : expect_res(Req0Imm26, Req0Ctrl);
         m_err   = w == 1 ? is_bad(Req1Ctrl) : is_bad(Req0Ctrl);
      end else if (RspReady) m_valid = 0;
   end

   always @(negedge CLK) begin
      int w;
      w = winner();
      chk("req0_ready", Req0Ready, w == 0);
      chk("req1_ready", Req1Ready, w == 1);
      chk("ext_imm", ExtImm26, w == 1 ? Req1Imm26 : Req0Imm26);
      chk("ext_ctrl", ExtCtrl, w == 1 ? Req1Ctrl : Req0Ctrl);
      chk("rsp_valid", RspValid, m_valid);
      if (m_valid) begin
         chk("rsp_bus", RspBusImm, m_bus);
         chk("rsp_id", RspId, m_id);
         chk("rsp_err", RspErr, m_err);
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RspReady = 1;
      cyc(); cyc();
      Req0Valid = 1;
      #1;
      chk("reset_ready", {Req0Ready, Req1Ready}, 0);
      chk("reset_valid", RspValid, 0);
      chk("reset_bus", RspBusImm, 0);
      Reset_L = 1;
      Req0Imm26 = 26'hABC << 10; Req0Ctrl = 3'b000;
      cyc();
      Req0Valid = 0;
      chk("single_valid", RspValid, 1);
      chk("single_bus", RspBusImm, 64'h0ABC);
      chk("single_id", RspId, 0);
      chk("single_err", RspErr, 0);
      cyc();
      Reset_L = 0;
      cyc();
      Reset_L = 1;
      Req0Valid = 1; Req0Imm26 = 26'h400; Req0Ctrl = 0;
      Req1Valid = 1; Req1Imm26 = 26'h800; Req1Ctrl = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("fair_valid", RspValid, 1);
         chk("fair_id", RspId, i % 2);
         chk("fair_bus", RspBusImm, (i % 2 == 1) ? 64'd2 : 64'd1);
      end
      RspReady = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_id", RspId, 1);
         chk("hold_bus", RspBusImm, 64'd2);
         chk("hold_ready", {Req0Ready, Req1Ready}, 0);
      end
      RspReady = 1;
      #1;
      chk("pass_ready", {Req0Ready, Req1Ready}, 2'b10);
      cyc();
      chk("pass_id", RspId, 0);
      chk("pass_bus", RspBusImm, 64'd1);
      Req0Valid = 0; Req1Valid = 0;
      cyc();
      Req1Valid = 1; Req1Ctrl = 3'b110; Req1Imm26 = 26'h2AAAAAA;
      cyc();
      Req1Valid = 0;
      chk("illegal_err", RspErr, 1);
      chk("illegal_bus", RspBusImm, 0);
      chk("illegal_id", RspId, 1);
      cyc();
      Req0Valid = 1; Req0Ctrl = 3'b010; Req0Imm26 = 26'h3FFFFFF;
      cyc();
      Req0Valid = 0;
`ifdef IMM_EXT_ARB_BSHIFT_EN
      chk("macro_bus", RspBusImm, 64'hFFFF_FFFF_FFFF_FFFC);
`else
      chk("macro_bus", RspBusImm, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
      cyc();
      for (int k = 0; k < 16; k++) begin
         Req0Valid = (k % 3) != 0;
         Req1Valid = (k % 2) == 0;
         Req0Ctrl  = 3'(k);
         Req1Ctrl  = 3'(k + 3);
         Req0Imm26 = 26'(32'h0123_4567 * (k + 1));
         Req1Imm26 = 26'(32'h89AB_CDEF ^ (k * 32'h1111));
         RspReady  = (k % 4) != 1;
         cyc();
      end
      Req0Valid = 0; Req1Valid = 0; RspReady = 1;
      cyc();
      Req0Valid = 1; Req0Ctrl = 0; Req0Imm26 = 26'h400;
      cyc();
      Req0Valid = 0; RspReady = 0;
      cyc();
      chk("rst_full", RspValid, 1);
      Reset_L = 0; Req0Valid = 1; Req1Valid = 1;
      #1;
      chk("rst_ready", {Req0Ready, Req1Ready}, 0);
      cyc();
      chk("rst_drop", RspValid, 0);
      Reset_L = 1; RspReady = 1;
      #1;
      chk("rst_first", {Req0Ready, Req1Ready}, 2'b10);
      cyc();
      chk("rst_first_id", RspId, 0);
      Req0Valid = 0; Req1Valid = 0;
      cyc(); cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
